// File: rtl/demux_4_stream.sv
// demux_4_stream: 1-to-4 valid/ready stream demultiplexer.
// The channel chosen on a packet's first beat stays locked until the beat carrying i_last.
// Each output owns a one-entry register slice, so a blocked channel back-pressures the
// input only and never stops other channels from draining.
// Optional feature (define DEMUX_BEAT_CNT_EN): per-channel saturating 16-bit beat counters
// with a synchronous clear (i_cnt_clr) exposed on o_cnt.
module demux_4_stream #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DATA_W-1:0]   i_din,
  input  logic                i_last,
  input  logic [1:0]          i_sel,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [4*DATA_W-1:0] o_dout,
  output logic [3:0]          o_last,
  output logic [3:0]          o_valid,
  input  logic [3:0]          i_ready,
`ifdef DEMUX_BEAT_CNT_EN
  input  logic                i_cnt_clr,
  output logic [4*16-1:0]     o_cnt,
`endif
  output logic                o_busy
);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          tgt;
  logic                in_fire;
  logic [3:0]          out_fire;
  logic [3:0]          load;
  logic [4*DATA_W-1:0] dout_q;
  logic [3:0]          last_q;
  logic [3:0]          valid_q;

  // Destination: live select on a packet's first beat, latched select for the rest
  always_comb begin
    tgt = (state_q == StBusy) ? sel_q : i_sel;
  end

  // Input is accepted when the target slot is empty or drains in this same cycle
  always_comb begin
    o_ready  = !valid_q[tgt] | i_ready[tgt];
    in_fire  = i_valid & o_ready;
    out_fire = valid_q & i_ready;
  end

  // One-hot load strobe for the slice receiving the accepted beat
  always_comb begin
    load = '0;
    for (int n = 0; n < 4; n++) begin
      load[n] = in_fire && (tgt == 2'(n));
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched packet destination
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q <= 2'd0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // FSM next state: a non-last first beat opens a packet, a last beat closes it
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire && !i_last) begin
          state_d = StBusy;
          sel_d   = i_sel;
        end
      end
      StBusy: begin
        if (in_fire && i_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM output decode, driven straight from the state register
  always_comb begin
    o_busy = (state_q == StBusy);
  end

  // Output slices: a load wins over a drain so a slot can refill as it empties
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout_q  <= '0;
      last_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n]) begin
          dout_q[n*DATA_W +: DATA_W] <= i_din;
          last_q[n]                  <= i_last;
          valid_q[n]                 <= 1'b1;
        end else if (out_fire[n]) begin
          valid_q[n] <= 1'b0;
        end
      end
    end
  end

  // Slice contents drive the outputs directly
  always_comb begin
    o_dout  = dout_q;
    o_last  = last_q;
    o_valid = valid_q;
  end

`ifdef DEMUX_BEAT_CNT_EN
  logic [15:0] cnt_q [4];

  // Per-channel drained-beat counters; clear beats a same-cycle increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= 16'd0;
      end
    end else if (i_cnt_clr) begin
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= 16'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (out_fire[n] && (cnt_q[n] != 16'hFFFF)) begin
          cnt_q[n] <= cnt_q[n] + 16'd1;
        end
      end
    end
  end

  // Pack counters onto the flat output bus
  always_comb begin
    o_cnt = '0;
    for (int n = 0; n < 4; n++) begin
      o_cnt[n*16 +: 16] = cnt_q[n];
    end
  end
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// Testbench for demux_4_stream: directed scenarios plus a randomized run checked against a
// per-channel queue model of the demultiplexer.
module tb_demux_4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        last;
  logic [1:0]  sel;
  logic        valid;
  logic        ready_o;
  logic [31:0] dout;
  logic [3:0]  olast;
  logic [3:0]  ovalid;
  logic [3:0]  rdy;
  logic        busy;
`ifdef DEMUX_BEAT_CNT_EN
  logic        cnt_clr;
  logic [63:0] cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: each channel holds at most one beat {last, data}
  logic [8:0] mq [4][$];
  bit         m_busy;
  logic [1:0] m_dst;

  demux_4_stream #(.DATA_W(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_din    (din),
    .i_last   (last),
    .i_sel    (sel),
    .i_valid  (valid),
    .o_ready  (ready_o),
    .o_dout   (dout),
    .o_last   (olast),
    .o_valid  (ovalid),
    .i_ready  (rdy),
`ifdef DEMUX_BEAT_CNT_EN
    .i_cnt_clr(cnt_clr),
    .o_cnt    (cnt),
`endif
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    valid = v;
    sel   = s;
    din   = d;
    last  = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    rdy   = 4'hF;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    rdy   = 4'hF;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovalid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b expected %b", ovalid, 4'b0000);
    end
    checks++;
    if (dout !== 32'h0) begin
      errors++; $display("FAIL reset_dout: got %h expected %h", dout, 32'h0);
    end
    checks++;
    if (olast !== 4'b0000) begin
      errors++; $display("FAIL reset_last: got %b expected %b", olast, 4'b0000);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
    end
    do_reset();
  endtask

  task automatic test_single_beat();
    rdy = 4'hF;
    drive(1'b1, 2'd2, 8'hA5, 1'b1);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b expected %b", ready_o, 1'b1);
    end
    next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (ovalid !== 4'b0100) begin
      errors++; $display("FAIL single_valid: got %b expected %b", ovalid, 4'b0100);
    end
    checks++;
    if (dout[23:16] !== 8'hA5) begin
      errors++; $display("FAIL single_data: got %h expected %h", dout[23:16], 8'hA5);
    end
    checks++;
    if (olast[2] !== 1'b1) begin
      errors++; $display("FAIL single_last: got %b expected %b", olast[2], 1'b1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy: got %b expected %b", busy, 1'b0);
    end
    next_cycle();
  endtask

  task automatic test_packet_lock();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11;
    exp_d[1] = 8'h22;
    exp_d[2] = 8'h33;
    rdy = 4'hF;
    drive(1'b1, 2'd1, 8'h11, 1'b0);
    next_cycle();
    for (int b = 0; b < 3; b++) begin
      if (b == 0) drive(1'b1, 2'd3, 8'h22, 1'b0);
      else if (b == 1) drive(1'b1, 2'd3, 8'h33, 1'b1);
      else drive(1'b0, 2'd3, 8'h00, 1'b0);
      @(negedge clk);
      checks++;
      if (ovalid !== 4'b0010) begin
        errors++; $display("FAIL lock_valid[%0d]: got %b expected %b", b, ovalid, 4'b0010);
      end
      checks++;
      if (dout[15:8] !== exp_d[b]) begin
        errors++; $display("FAIL lock_data[%0d]: got %h expected %h", b, dout[15:8], exp_d[b]);
      end
      checks++;
      if (olast[1] !== (b == 2)) begin
        errors++; $display("FAIL lock_last[%0d]: got %b expected %b", b, olast[1], b == 2);
      end
      checks++;
      if (busy !== (b != 2)) begin
        errors++; $display("FAIL lock_busy[%0d]: got %b expected %b", b, busy, b != 2);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (ovalid !== 4'b0000) begin
      errors++; $display("FAIL lock_drained: got %b expected %b", ovalid, 4'b0000);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    rdy = 4'b0110;
    drive(1'b1, 2'd3, 8'h3C, 1'b1);
    next_cycle();
    drive(1'b1, 2'd0, 8'hA0, 1'b1);
    next_cycle();
    drive(1'b1, 2'd0, 8'hB0, 1'b1);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_ready_full: got %b expected %b", ready_o, 1'b0);
    end
    checks++;
    if (ovalid !== 4'b1001) begin
      errors++; $display("FAIL bp_valid_full: got %b expected %b", ovalid, 4'b1001);
    end
    next_cycle();
    rdy[3] = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (ovalid !== 4'b0001) begin
      errors++; $display("FAIL bp_ch3_drain: got %b expected %b", ovalid, 4'b0001);
    end
    checks++;
    if (dout[7:0] !== 8'hA0) begin
      errors++; $display("FAIL bp_ch0_hold: got %h expected %h", dout[7:0], 8'hA0);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_ready_stall: got %b expected %b", ready_o, 1'b0);
    end
    next_cycle();
    rdy[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_ready_release: got %b expected %b", ready_o, 1'b1);
    end
    next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (ovalid !== 4'b0001) begin
      errors++; $display("FAIL bp_refill_valid: got %b expected %b", ovalid, 4'b0001);
    end
    checks++;
    if (dout[7:0] !== 8'hB0) begin
      errors++; $display("FAIL bp_refill_data: got %h expected %h", dout[7:0], 8'hB0);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    rdy = 4'hF;
    drive(1'b1, 2'd0, 8'h41, 1'b0);
    next_cycle();
    drive(1'b1, 2'd1, 8'h42, 1'b1);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || dout[7:0] !== 8'h41) begin
      errors++; $display("FAIL b2b_beat0: got ready=%b data=%h expected ready=1 data=41", ready_o, dout[7:0]);
    end
    next_cycle();
    drive(1'b1, 2'd2, 8'h51, 1'b1);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %b expected %b", ready_o, 1'b1);
    end
    checks++;
    if (ovalid !== 4'b0001 || dout[7:0] !== 8'h42 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_ch0_end: got valid=%b data=%h busy=%b expected valid=0001 data=42 busy=0", ovalid, dout[7:0], busy);
    end
    next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (ovalid !== 4'b0100 || dout[23:16] !== 8'h51) begin
      errors++; $display("FAIL b2b_ch2: got valid=%b data=%h expected valid=0100 data=51", ovalid, dout[23:16]);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_packet();
    rdy = 4'hF;
    drive(1'b1, 2'd1, 8'h61, 1'b0);
    next_cycle();
    drive(1'b1, 2'd1, 8'h62, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovalid !== 4'b0000) begin
      errors++; $display("FAIL midrst_valid: got %b expected %b", ovalid, 4'b0000);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: got %b expected %b", busy, 1'b0);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive(1'b1, 2'd0, 8'h71, 1'b1);
    next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (ovalid !== 4'b0001 || dout[7:0] !== 8'h71 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_after: got valid=%b data=%h busy=%b expected valid=0001 data=71 busy=0", ovalid, dout[7:0], busy);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic       exp_rdy;
    bit         fire;
    do_reset();
    for (int n = 0; n < 4; n++) mq[n].delete();
    m_busy = 1'b0;
    m_dst  = 2'd0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      drive($urandom_range(0, 9) < 7, 2'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
      rdy = 4'($urandom);
      @(negedge clk);
      t       = m_busy ? m_dst : sel;
      exp_rdy = (mq[t].size() == 0) || rdy[t];
      checks++;
      if (ready_o !== exp_rdy) begin
        errors++; $display("FAIL rand_ready@%0d: got %b expected %b", c, ready_o, exp_rdy);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++; $display("FAIL rand_busy@%0d: got %b expected %b", c, busy, m_busy);
      end
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (ovalid[n] !== (mq[n].size() != 0)) begin
          errors++; $display("FAIL rand_valid%0d@%0d: got %b expected %b", n, c, ovalid[n], mq[n].size() != 0);
        end else if (mq[n].size() != 0 && {olast[n], dout[n*8 +: 8]} !== mq[n][0]) begin
          errors++; $display("FAIL rand_beat%0d@%0d: got %h expected %h", n, c, {olast[n], dout[n*8 +: 8]}, mq[n][0]);
        end
      end
      // Advance the model with the inputs that the coming edge will see
      fire = valid && exp_rdy;
      for (int n = 0; n < 4; n++) begin
        if (mq[n].size() != 0 && rdy[n]) void'(mq[n].pop_front());
      end
      if (fire) begin
        mq[t].push_back({last, din});
        if (!m_busy && !last) begin
          m_busy = 1'b1;
          m_dst  = sel;
        end else if (m_busy && last) begin
          m_busy = 1'b0;
        end
      end
    end
    next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    rdy = 4'hF;
    repeat (2) next_cycle();
  endtask

`ifdef DEMUX_BEAT_CNT_EN
  task automatic test_beat_cnt();
    cnt_clr = 1'b0;
    do_reset();
    rdy = 4'hF;
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, 2'd1, 8'(b), 1'b1);
      next_cycle();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (cnt[31:16] !== 16'd5) begin
      errors++; $display("FAIL cnt_five: got %0d expected %0d", cnt[31:16], 5);
    end
    drive(1'b1, 2'd1, 8'h99, 1'b1);
    next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt[31:16] !== 16'd0) begin
      errors++; $display("FAIL cnt_clear: got %0d expected %0d", cnt[31:16], 0);
    end
    drive(1'b1, 2'd0, 8'h5A, 1'b1);
    repeat (65537) next_cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (cnt[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_saturate: got %h expected %h", cnt[15:0], 16'hFFFF);
    end
  endtask
`endif

  initial begin
`ifdef DEMUX_BEAT_CNT_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
`ifdef DEMUX_BEAT_CNT_EN
    test_beat_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_4_stream.md
Name: demux_4_stream

Overview:
- 1-to-4 stream demultiplexer with valid/ready handshake. It is the distribution-side counterpart of mux_4.
- Routes each packet from a single input stream to one of four output channels selected by i_sel.
- Selection is locked for the whole packet, from its first beat through the beat with i_last.
- Each output has a one-entry register slice, so one blocked channel stalls only the input, never other channels' drains.

Parameters:
- DATA_W, 8, width of the data word on the input and on each output.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_din  input  DATA_W  input data word.
- i_last  input  1  marks the final beat of a packet.
- i_sel  input  2  destination channel; sampled only on the first beat of a packet.
- i_valid  input  1  input beat valid.
- o_ready  output  1  input beat accepted this cycle when i_valid and o_ready are both high.
- o_dout  output  4*DATA_W  channel n data in bits [n*DATA_W +: DATA_W].
- o_last  output  4  per-channel last flag.
- o_valid  output  4  per-channel valid.
- i_ready  input  4  per-channel downstream ready.
- o_busy  output  1  high while a multi-beat packet is in progress (BUSY state).

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - o_valid = 0, o_dout = 0, o_last = 0, o_busy = 0.
  - State goes to IDLE and the latched select is cleared to 0.
  - Reset mid-packet discards the partial packet and all held beats.
- Definitions:
  - in_fire = i_valid & o_ready.
  - out_fire[n] = o_valid[n] & i_ready[n].
- Target channel:
  - In IDLE, tgt = i_sel.
  - In BUSY, tgt = the latched select; i_sel is ignored.
- o_ready = !o_valid[tgt] | i_ready[tgt]. This is combinational; a full slot can be refilled in the same cycle it drains.
- Slice n, on each clock edge:
  - If in_fire and tgt == n: load i_din and i_last, set o_valid[n].
  - Else if out_fire[n]: clear o_valid[n].
  - Otherwise: hold.
- Latency: an accepted beat appears on o_dout[tgt] on the next cycle. Sustained throughput is 1 beat/cycle per channel when downstream is always ready.
- FSM:
  - IDLE to BUSY: on in_fire with i_last = 0; latch i_sel.
  - IDLE to IDLE: on in_fire with i_last = 1 (single-beat packet; no latch needed).
  - BUSY to IDLE: on in_fire with i_last = 1.
  - BUSY holds in all other cases.
  - o_busy = (state == BUSY), registered.
- Boundary conditions:
  - A changing i_sel during BUSY has no effect.
  - A new packet may start on the cycle right after a last beat is accepted, to any channel.
  - Non-target channels keep draining independently while the input is stalled.
  - If i_valid is low, nothing changes except drains.
  - o_dout and o_last hold their value while o_valid[n] = 0; content then is don't-care for the bench.
- No beat is ever dropped or duplicated.
- Within a channel, beats come out in acceptance order.

Optional Feature:
- Macro: DEMUX_BEAT_CNT_EN.
- Defined:
  - Adds input i_cnt_clr (1 bit, synchronous clear).
  - Adds output o_cnt (4*16 bits; channel n in bits [n*16 +: 16]).
  - Each counter increments on out_fire[n] and saturates at 16'hFFFF.
  - i_cnt_clr zeroes all four counters and wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist; datapath behaviour is identical either way.

Test Plan:
- Single-beat packet: i_sel=2, i_din=8'hA5, i_last=1, all i_ready=1.
  - Next cycle: o_valid=4'b0100, channel 2 data = 8'hA5, o_last[2]=1.
  - o_busy stays 0.
- Packet lock: 3-beat packet 11,22,33 with i_sel=1 on beat 0, then i_sel=3 on beats 1–2.
  - All three beats appear only on channel 1; o_last[1]=1 on 33 only.
  - o_busy is 1 after beat 0 and returns to 0 after beat 33.
- Backpressure isolation: hold i_ready[0]=0, send beat to ch0, then a packet to ch0 while ch3 drains.
  - o_ready=0 once slot 0 is full; ch3 continues draining.
  - Raising i_ready[0] releases the held beat and, in the same cycle, accepts the next one (o_ready=1).
- Back-to-back packets: packet ch0 (last), then immediately a packet to ch2 on the next cycle.
  - Both are accepted with no bubble; ordering is preserved per channel.
- Reset mid-packet: assert i_rst_n=0 during beat 2 of a 4-beat packet.
  - o_valid=0, o_busy=0 immediately (asynchronous).
  - After release, a new packet with i_sel=0 routes to ch0.
- DEMUX_BEAT_CNT_EN:
  - 5 beats to ch1 gives o_cnt ch1 = 5.
  - Pulsing i_cnt_clr during a drain gives 0 that cycle.
  - Forcing 65535 drains holds the count at 16'hFFFF.
